perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
- Owns the nine 16-bit performance counters that the MMIO counter decoder reads via LDI and clears via STI.
- Takes raw event strobes from the I-cache, D-cache, L2, branch predictor and pipeline stall logic.
- Takes per-counter clear strobes from the MMIO decoder.
- Presents the live count values back to the decoder.
- Sits beside the datapath, clocked with the CPU core.

Parameters:
- WIDTH, 16, counter width; matches lc3b_word.
- EDGE_MASK, 9'h000, per-counter select. Bit i = 1 counts rising edges of event i. Bit i = 0 counts every cycle event i is high.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- count_en  in  1  global count enable; when low, all counters hold (clears still act)
- ev_i_cache_hit  in  1  I-cache hit event
- ev_i_cache_miss  in  1  I-cache miss event
- ev_d_cache_hit  in  1  D-cache hit event
- ev_d_cache_miss  in  1  D-cache miss event
- ev_l2_cache_hit  in  1  L2 hit event
- ev_l2_cache_miss  in  1  L2 miss event
- ev_branch  in  1  branch resolved
- ev_mispredict  in  1  branch mispredicted
- ev_stall  in  1  pipeline stalled this cycle
- clr  in  9  clear strobes, index order below; driven from the MMIO decoder reset_* outputs
- i_cache_hits, i_cache_misses, d_cache_hits, d_cache_misses, l2_cache_hits, l2_cache_misses, total_branches, mispredictions, total_stalls  out  WIDTH each  registered counts
- overflow  out  9  sticky per-counter overflow flags, index order below

Behaviour:
- Counter index order (all 9-bit vectors):
  - 0 i_cache_hits, 1 i_cache_misses, 2 d_cache_hits, 3 d_cache_misses
  - 4 l2_cache_hits, 5 l2_cache_misses, 6 total_branches, 7 mispredictions, 8 total_stalls
- Reset: rst_n low asynchronously forces all counts to 0, overflow to 0, and edge history to 0, including mid-increment. Outputs are valid 0 from the first cycle after rst_n rises.
- Increment condition, per counter i:
  - inc_i = count_en & (EDGE_MASK[i] ? (ev_i & ~ev_prev_i) : ev_i)
  - ev_prev_i is registered every cycle regardless of count_en, so an event held through an enable rise is not counted as an edge.
- Update priority per counter per cycle:
  - clr[i] high: count = 0, overflow[i] = 0; a simultaneous inc is dropped.
  - else inc_i at all-ones: SATURATE=1 holds all-ones and sets overflow[i]; SATURATE=0 goes to 0 and sets overflow[i].
  - else inc_i: count + 1.
  - else hold.
- Clear held high for several cycles (MMIO STI stalled on memory) keeps the counter at 0 for every such cycle. Counting resumes the cycle after clr falls.
- Latency:
  - Event at cycle N is visible on the count output at N+1.
  - Clear at cycle N gives 0 at N+1.
  - Outputs come straight from registers; no combinational path from any input to any output.
- Counters are independent; any mix of simultaneous events and clears across counters is legal.
- overflow[i] is cleared only by reset or clr[i].
- No consistency rule between mispredictions and total_branches; each counter counts its own input.

Decomposition:
- Shared package perf_types:
  - NUM_PERF_COUNTERS = 9
  - perf_idx_t enum holding the index order above
  - MMIO address constants 16'hFFFF down to 16'hFFF7 mapped to that order, so decoder and bank share one source
- One sub-module perf_counter: single counter plus edge register, overflow flag and priority logic, parameterised by WIDTH, EDGE, SATURATE.
- perf_counter_bank instantiates nine perf_counter and maps the event ports and clr bits to them.

Test Plan:
- Reset: rst_n low mid-run with all counts nonzero -> all counts and overflow read 0 the same cycle (async); the count after release stays 0 with no events.
- Level count: EDGE_MASK=0, ev_stall high 5 cycles with count_en=1 -> total_stalls=5 one cycle after the last high cycle; other counters stay 0.
- Edge count: EDGE_MASK[0]=1, ev_i_cache_hit high 4 cycles, low 1, high 2 -> i_cache_hits=2.
- Clear priority: d_cache_misses=7, clr[3] and ev_d_cache_miss high the same cycle -> next cycle 0. Then one event -> 1.
- Saturation: preload to 16'hFFFE by events, then 3 events with SATURATE=1 -> 16'hFFFF and overflow[8]=1. Same with SATURATE=0 -> 16'h0001 and overflow set. clr clears both.
- Enable/multi-clear: count_en=0 with all events high 3 cycles -> no change. Then clr=9'h1FF held 2 cycles -> all 0 while held; count_en=1 with ev_branch -> total_branches increments from the cycle after clr falls.

Source files
------------

// File: rtl/perf_types_pkg.sv
// Shared performance-counter definitions: counter index order and the MMIO
// addresses the counter decoder uses, so decoder and bank agree on one map.
package perf_types;

  localparam int NUM_PERF_COUNTERS = 9;

  typedef enum logic [3:0] {
    IDX_I_CACHE_HITS    = 4'd0,
    IDX_I_CACHE_MISSES  = 4'd1,
    IDX_D_CACHE_HITS    = 4'd2,
    IDX_D_CACHE_MISSES  = 4'd3,
    IDX_L2_CACHE_HITS   = 4'd4,
    IDX_L2_CACHE_MISSES = 4'd5,
    IDX_TOTAL_BRANCHES  = 4'd6,
    IDX_MISPREDICTIONS  = 4'd7,
    IDX_TOTAL_STALLS    = 4'd8
  } perf_idx_t;

  // Counters occupy the top of the address space, descending in index order.
  localparam logic [15:0] PERF_BASE_ADDR        = 16'hFFFF;
  localparam logic [15:0] ADDR_I_CACHE_HITS     = 16'hFFFF;
  localparam logic [15:0] ADDR_I_CACHE_MISSES   = 16'hFFFE;
  localparam logic [15:0] ADDR_D_CACHE_HITS     = 16'hFFFD;
  localparam logic [15:0] ADDR_D_CACHE_MISSES   = 16'hFFFC;
  localparam logic [15:0] ADDR_L2_CACHE_HITS    = 16'hFFFB;
  localparam logic [15:0] ADDR_L2_CACHE_MISSES  = 16'hFFFA;
  localparam logic [15:0] ADDR_TOTAL_BRANCHES   = 16'hFFF9;
  localparam logic [15:0] ADDR_MISPREDICTIONS   = 16'hFFF8;
  localparam logic [15:0] ADDR_TOTAL_STALLS     = 16'hFFF7;

  function automatic logic [15:0] perf_addr(input perf_idx_t idx);
    return PERF_BASE_ADDR - {12'h000, idx};
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One performance counter: optional rising-edge detect, clear-over-increment
// priority, saturate or wrap at all-ones, sticky overflow flag.
module perf_counter #(
  parameter int WIDTH    = 16,
  parameter bit EDGE     = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  input  logic             ev,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic ev_prev;
  logic inc;
  logic at_max;

  // Edge history tracks the raw event even while counting is disabled, so an
  // event already high when count_en rises is not mistaken for a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ev_prev <= 1'b0;
    else        ev_prev <= ev;
  end

  assign inc    = count_en & (EDGE ? (ev & ~ev_prev) : ev);
  assign at_max = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        count    <= SATURATE ? '1 : '0;
        overflow <= 1'b1;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of nine performance counters read and cleared by the MMIO counter
// decoder; maps the named event strobes and clear bits onto perf_counter.
module perf_counter_bank
  import perf_types::*;
#(
  parameter int                           WIDTH     = 16,
  parameter logic [NUM_PERF_COUNTERS-1:0] EDGE_MASK = 9'h000,
  parameter bit                           SATURATE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         count_en,
  input  logic                         ev_i_cache_hit,
  input  logic                         ev_i_cache_miss,
  input  logic                         ev_d_cache_hit,
  input  logic                         ev_d_cache_miss,
  input  logic                         ev_l2_cache_hit,
  input  logic                         ev_l2_cache_miss,
  input  logic                         ev_branch,
  input  logic                         ev_mispredict,
  input  logic                         ev_stall,
  input  logic [NUM_PERF_COUNTERS-1:0] clr,
  output logic [WIDTH-1:0]             i_cache_hits,
  output logic [WIDTH-1:0]             i_cache_misses,
  output logic [WIDTH-1:0]             d_cache_hits,
  output logic [WIDTH-1:0]             d_cache_misses,
  output logic [WIDTH-1:0]             l2_cache_hits,
  output logic [WIDTH-1:0]             l2_cache_misses,
  output logic [WIDTH-1:0]             total_branches,
  output logic [WIDTH-1:0]             mispredictions,
  output logic [WIDTH-1:0]             total_stalls,
  output logic [NUM_PERF_COUNTERS-1:0] overflow
);

  logic [NUM_PERF_COUNTERS-1:0] ev;
  logic [WIDTH-1:0]             cnt [NUM_PERF_COUNTERS];

  assign ev[IDX_I_CACHE_HITS]    = ev_i_cache_hit;
  assign ev[IDX_I_CACHE_MISSES]  = ev_i_cache_miss;
  assign ev[IDX_D_CACHE_HITS]    = ev_d_cache_hit;
  assign ev[IDX_D_CACHE_MISSES]  = ev_d_cache_miss;
  assign ev[IDX_L2_CACHE_HITS]   = ev_l2_cache_hit;
  assign ev[IDX_L2_CACHE_MISSES] = ev_l2_cache_miss;
  assign ev[IDX_TOTAL_BRANCHES]  = ev_branch;
  assign ev[IDX_MISPREDICTIONS]  = ev_mispredict;
  assign ev[IDX_TOTAL_STALLS]    = ev_stall;

  for (genvar g = 0; g < NUM_PERF_COUNTERS; g++) begin : g_ctr
    perf_counter #(
      .WIDTH    (WIDTH),
      .EDGE     (EDGE_MASK[g]),
      .SATURATE (SATURATE)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_en (count_en),
      .ev       (ev[g]),
      .clr      (clr[g]),
      .count    (cnt[g]),
      .overflow (overflow[g])
    );
  end

  assign i_cache_hits    = cnt[IDX_I_CACHE_HITS];
  assign i_cache_misses  = cnt[IDX_I_CACHE_MISSES];
  assign d_cache_hits    = cnt[IDX_D_CACHE_HITS];
  assign d_cache_misses  = cnt[IDX_D_CACHE_MISSES];
  assign l2_cache_hits   = cnt[IDX_L2_CACHE_HITS];
  assign l2_cache_misses = cnt[IDX_L2_CACHE_MISSES];
  assign total_branches  = cnt[IDX_TOTAL_BRANCHES];
  assign mispredictions  = cnt[IDX_MISPREDICTIONS];
  assign total_stalls    = cnt[IDX_TOTAL_STALLS];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two instances (mixed edge mask + saturate,
// all-level + wrap) share stimulus; a scoreboard checks every driven cycle.
module tb_perf_counter_bank;

  localparam logic [8:0] MASK_A = 9'h055;
  localparam logic [8:0] MASK_B = 9'h000;
  localparam int         MAXV   = 65535;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [8:0] ev_v;
  logic [8:0] clr_v;

  wire [8:0][15:0] a_cnt;
  wire [8:0][15:0] b_cnt;
  wire [8:0]       a_ovf;
  wire [8:0]       b_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0][8:0][15:0] cnt;
    logic [1:0][8:0]       ovf;
  } exp_t;

  exp_t exp_q [$];

  // Reference model: plain integer counts per instance.
  int m_cnt [2][9];
  bit m_ovf [2][9];
  bit m_prev [9];

  string names [9] = '{"i_hit", "i_miss", "d_hit", "d_miss", "l2_hit",
                       "l2_miss", "branches", "mispred", "stalls"};

  perf_counter_bank #(.WIDTH(16), .EDGE_MASK(MASK_A), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .count_en(en),
    .ev_i_cache_hit(ev_v[0]), .ev_i_cache_miss(ev_v[1]),
    .ev_d_cache_hit(ev_v[2]), .ev_d_cache_miss(ev_v[3]),
    .ev_l2_cache_hit(ev_v[4]), .ev_l2_cache_miss(ev_v[5]),
    .ev_branch(ev_v[6]), .ev_mispredict(ev_v[7]), .ev_stall(ev_v[8]),
    .clr(clr_v),
    .i_cache_hits(a_cnt[0]), .i_cache_misses(a_cnt[1]),
    .d_cache_hits(a_cnt[2]), .d_cache_misses(a_cnt[3]),
    .l2_cache_hits(a_cnt[4]), .l2_cache_misses(a_cnt[5]),
    .total_branches(a_cnt[6]), .mispredictions(a_cnt[7]),
    .total_stalls(a_cnt[8]), .overflow(a_ovf)
  );

  perf_counter_bank #(.WIDTH(16), .EDGE_MASK(MASK_B), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .count_en(en),
    .ev_i_cache_hit(ev_v[0]), .ev_i_cache_miss(ev_v[1]),
    .ev_d_cache_hit(ev_v[2]), .ev_d_cache_miss(ev_v[3]),
    .ev_l2_cache_hit(ev_v[4]), .ev_l2_cache_miss(ev_v[5]),
    .ev_branch(ev_v[6]), .ev_mispredict(ev_v[7]), .ev_stall(ev_v[8]),
    .clr(clr_v),
    .i_cache_hits(b_cnt[0]), .i_cache_misses(b_cnt[1]),
    .d_cache_hits(b_cnt[2]), .d_cache_misses(b_cnt[3]),
    .l2_cache_hits(b_cnt[4]), .l2_cache_misses(b_cnt[5]),
    .total_branches(b_cnt[6]), .mispredictions(b_cnt[7]),
    .total_stalls(b_cnt[8]), .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 9; i++) begin
        m_cnt[k][i] = 0;
        m_ovf[k][i] = 1'b0;
      end
    for (int i = 0; i < 9; i++) m_prev[i] = 1'b0;
  endfunction

  function automatic void model_step(input logic [8:0] ev, input logic [8:0] c,
                                     input logic e);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 9; i++) begin
        bit edge_mode;
        bit counted;
        int next;
        edge_mode = (k == 0) ? MASK_A[i] : MASK_B[i];
        counted   = e && ev[i] && !(edge_mode && m_prev[i]);
        if (c[i]) begin
          m_cnt[k][i] = 0;
          m_ovf[k][i] = 1'b0;
        end else if (counted) begin
          next = m_cnt[k][i] + 1;
          if (next > MAXV) begin
            m_ovf[k][i] = 1'b1;
            next = (k == 0) ? MAXV : next - (MAXV + 1);
          end
          m_cnt[k][i] = next;
        end
      end
    for (int i = 0; i < 9; i++) m_prev[i] = ev[i];
  endfunction

  function automatic void push_expect();
    exp_t e;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 9; i++) begin
        e.cnt[k][i] = 16'(m_cnt[k][i]);
        e.ovf[k][i] = m_ovf[k][i];
      end
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input logic [8:0] ev, input logic [8:0] c, input logic e,
                       input bit chk);
    @(negedge clk);
    ev_v  = ev;
    clr_v = c;
    en    = e;
    model_step(ev, c, e);
    if (chk) push_expect();
  endtask

  // Monitor: outputs are registered, so each driven cycle is checked just
  // after the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 9; i++) begin
          check({"a_", names[i]}, int'(a_cnt[i]), int'(e.cnt[0][i]));
          check({"a_ovf_", names[i]}, int'(a_ovf[i]), int'(e.ovf[0][i]));
          check({"b_", names[i]}, int'(b_cnt[i]), int'(e.cnt[1][i]));
          check({"b_ovf_", names[i]}, int'(b_ovf[i]), int'(e.ovf[1][i]));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] rev;
    logic [8:0] rclr;
    logic       ren;
    logic [6:0] edge_pat;

    rst_n = 1'b0;
    ev_v  = '0;
    clr_v = '0;
    en    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      check({"rst_a_", names[i]}, int'(a_cnt[i]), 0);
      check({"rst_b_", names[i]}, int'(b_cnt[i]), 0);
    end
    check("rst_a_ovf", int'(a_ovf), 0);
    check("rst_b_ovf", int'(b_ovf), 0);
    rst_n = 1'b1;

    // Level count on stalls
    repeat (5) cycle(9'h100, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("level_stalls_a", int'(a_cnt[8]), 5);
    check("level_stalls_b", int'(b_cnt[8]), 5);
    check("level_other_a", int'(a_cnt[6]), 0);
    cycle(9'h000, 9'h000, 1'b1, 1'b1);

    // Edge count on i-cache hits: high 4, low 1, high 2
    edge_pat = 7'b1101111;
    for (int j = 0; j < 7; j++) cycle({8'h00, edge_pat[j]}, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("edge_ihit_a", int'(a_cnt[0]), 2);
    check("edge_ihit_b", int'(b_cnt[0]), 6);
    cycle(9'h000, 9'h000, 1'b1, 1'b1);

    // Clear beats a simultaneous increment
    repeat (7) cycle(9'h008, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("clrpri_pre", int'(a_cnt[3]), 7);
    cycle(9'h008, 9'h008, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("clrpri_zero", int'(a_cnt[3]), 0);
    cycle(9'h008, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("clrpri_one", int'(a_cnt[3]), 1);

    // Disabled counting, then held multi-clear with branch held high
    repeat (3) cycle(9'h1FF, 9'h000, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("en_hold_stalls", int'(a_cnt[8]), 5);
    repeat (2) cycle(9'h040, 9'h1FF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("mclr_branches_b", int'(b_cnt[6]), 0);
    check("mclr_stalls_a", int'(a_cnt[8]), 0);
    repeat (3) cycle(9'h040, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("resume_branches_b", int'(b_cnt[6]), 3);
    check("held_edge_branches_a", int'(a_cnt[6]), 0);

    // Random traffic
    for (int j = 0; j < 1500; j++) begin
      rev  = 9'($urandom);
      rclr = 9'($urandom & $urandom & $urandom & $urandom);
      ren  = ($urandom_range(9, 0) != 0);
      cycle(rev, rclr, ren, 1'b1);
    end

    // Saturation / wrap on stalls
    cycle(9'h000, 9'h1FF, 1'b1, 1'b1);
    repeat (65534) cycle(9'h100, 9'h000, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("preload_a", int'(a_cnt[8]), 16'hFFFE);
    repeat (3) cycle(9'h100, 9'h000, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("sat_a", int'(a_cnt[8]), 16'hFFFF);
    check("sat_ovf_a", int'(a_ovf[8]), 1);
    check("wrap_b", int'(b_cnt[8]), 16'h0001);
    check("wrap_ovf_b", int'(b_ovf[8]), 1);
    cycle(9'h000, 9'h100, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("satclr_a", int'(a_cnt[8]), 0);
    check("satclr_ovf_a", int'(a_ovf[8]), 0);
    check("satclr_b", int'(b_cnt[8]), 0);
    check("satclr_ovf_b", int'(b_ovf[8]), 0);

    // Asynchronous reset mid-run with every counter nonzero
    repeat (3) cycle(9'h1FF, 9'h000, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      check({"arst_a_", names[i]}, int'(a_cnt[i]), 0);
      check({"arst_b_", names[i]}, int'(b_cnt[i]), 0);
    end
    check("arst_a_ovf", int'(a_ovf), 0);
    check("arst_b_ovf", int'(b_ovf), 0);
    model_reset();
    ev_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(9'h000, 9'h000, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
